// File: rtl/single_step_ctrl_if.sv
// Signal bundle between the step controller, the switch debouncer and the CPU.
// The controller takes the master side; the debouncer/CPU side takes slave.
interface single_step_ctrl_if;
  logic       stable_sw7;
  logic       run_mode;
  logic       cpu_ack;
  logic       cpu_en;
  logic       busy;
  logic [7:0] step_count;
  logic       timeout_err;

  modport master (
    input  stable_sw7,
    input  run_mode,
    input  cpu_ack,
    output cpu_en,
    output busy,
    output step_count,
    output timeout_err
  );

  modport slave (
    output stable_sw7,
    output run_mode,
    output cpu_ack,
    input  cpu_en,
    input  busy,
    input  step_count,
    input  timeout_err
  );
endinterface

// File: rtl/single_step_ctrl.sv
// Turns each clean 0->1 press of the step switch into exactly one acknowledged
// CPU step, followed by a hold-off; also offers a free-run mode.
module single_step_ctrl #(
  parameter int unsigned HOLDOFF_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  single_step_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP    = 2'd1,
    HOLDOFF = 2'd2,
    RUN     = 2'd3
  } state_t;

  localparam logic [19:0] HOLD_LAST = 20'(HOLDOFF_CYCLES - 1);
  localparam logic [19:0] TO_LAST   = 20'(TIMEOUT_CYCLES - 1);

  state_t      state_reg;
  logic [19:0] cnt_reg;
  logic        sw_q;
  logic        press;

  // sw_q resets high so a switch already held at reset release never steps.
  assign press = bus.stable_sw7 & ~sw_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      sw_q            <= 1'b1;
      bus.cpu_en      <= 1'b0;
      bus.busy        <= 1'b0;
      bus.step_count  <= 8'd0;
      bus.timeout_err <= 1'b0;
    end else begin
      sw_q <= bus.stable_sw7;
      case (state_reg)
        IDLE: begin
          if (bus.run_mode) begin
            state_reg  <= RUN;
            bus.cpu_en <= 1'b1;
            bus.busy   <= 1'b0;
          end else if (press) begin
            state_reg  <= STEP;
            cnt_reg    <= '0;
            bus.cpu_en <= 1'b1;
            bus.busy   <= 1'b1;
          end
        end
        STEP: begin
          // An ack landing on the timeout cycle still counts as a good step.
          if (bus.cpu_ack) begin
            state_reg      <= HOLDOFF;
            cnt_reg        <= '0;
            bus.step_count <= bus.step_count + 8'd1;
            bus.cpu_en     <= 1'b0;
            bus.busy       <= 1'b1;
          end else if (cnt_reg == TO_LAST) begin
            state_reg       <= IDLE;
            bus.timeout_err <= 1'b1;
            bus.cpu_en      <= 1'b0;
            bus.busy        <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 20'd1;
          end
        end
        HOLDOFF: begin
          if (cnt_reg == HOLD_LAST) begin
            state_reg <= IDLE;
            bus.busy  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 20'd1;
          end
        end
        RUN: begin
          if (!bus.run_mode) begin
            state_reg  <= IDLE;
            bus.cpu_en <= 1'b0;
          end
        end
        default: begin
          state_reg  <= IDLE;
          bus.cpu_en <= 1'b0;
          bus.busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_single_step_ctrl.sv
// Directed bench for single_step_ctrl: press/ack timing, hold-off, timeout,
// free-run, step counter wrap and asynchronous reset.
module tb_single_step_ctrl;

  localparam int unsigned HOLDOFF = 4;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;

  single_step_ctrl_if ssc_if ();

  single_step_ctrl #(
    .HOLDOFF_CYCLES (HOLDOFF),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ssc_if.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int exp_count = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance n clock edges; outputs are sampled 1 ns after the edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // New press from IDLE, ack raised 'delay' cycles after cpu_en rises.
  // Returns how many sampled cycles cpu_en was high.
  task automatic do_step(input int delay, output int hi);
    ssc_if.stable_sw7 = 1'b0;
    tick();
    ssc_if.stable_sw7 = 1'b1;
    tick();
    hi = int'(ssc_if.cpu_en);
    repeat (delay - 1) begin
      tick();
      hi += int'(ssc_if.cpu_en);
    end
    ssc_if.cpu_ack = 1'b1;
    tick();
    ssc_if.cpu_ack    = 1'b0;
    ssc_if.stable_sw7 = 1'b0;
    hi += int'(ssc_if.cpu_en);
  endtask

  // Counts sampled cycles with busy high, starting from the current sample.
  task automatic wait_idle(output int n);
    n = 0;
    while (ssc_if.busy && n < 100) begin
      n++;
      tick();
    end
    if (n >= 100) chk("wait_idle_bound", 32'(n), 32'd0);
  endtask

  task automatic check_outputs(input string tag, input logic en, input logic bsy,
                               input int cnt, input logic terr);
    chk({tag, "_cpu_en"}, 32'(ssc_if.cpu_en), 32'(en));
    chk({tag, "_busy"}, 32'(ssc_if.busy), 32'(bsy));
    chk({tag, "_step_count"}, 32'(ssc_if.step_count), 32'(cnt));
    chk({tag, "_timeout_err"}, 32'(ssc_if.timeout_err), 32'(terr));
  endtask

  initial begin
    int hi;
    int n;
    int en_seen;

    reset             = 1'b1;
    ssc_if.stable_sw7 = 1'b1;
    ssc_if.run_mode   = 1'b0;
    ssc_if.cpu_ack    = 1'b0;
    tick(3);
    check_outputs("reset", 1'b0, 1'b0, 0, 1'b0);

    // Switch held across reset release must not step.
    reset = 1'b0;
    en_seen = 0;
    repeat (50) begin
      tick();
      en_seen += int'(ssc_if.cpu_en);
    end
    chk("held_sw_no_step", 32'(en_seen), 32'd0);
    chk("held_sw_count", 32'(ssc_if.step_count), 32'd0);

    // First step: ack 3 cycles after cpu_en rises.
    do_step(3, hi);
    exp_count++;
    chk("step1_en_cycles", 32'(hi), 32'd3);
    chk("step1_count", 32'(ssc_if.step_count), 32'(exp_count));
    wait_idle(n);
    chk("step1_holdoff_len", 32'(n), 32'(HOLDOFF));

    // Press during hold-off is dropped.
    do_step(2, hi);
    exp_count++;
    chk("step2_count", 32'(ssc_if.step_count), 32'(exp_count));
    tick();
    ssc_if.stable_sw7 = 1'b1;
    tick();
    chk("holdoff_press_busy", 32'(ssc_if.busy), 32'd1);
    wait_idle(n);
    en_seen = 0;
    repeat (5) begin
      tick();
      en_seen += int'(ssc_if.cpu_en);
    end
    chk("holdoff_press_dropped_en", 32'(en_seen), 32'd0);
    chk("holdoff_press_dropped_cnt", 32'(ssc_if.step_count), 32'(exp_count));
    do_step(1, hi);
    exp_count++;
    chk("step3_count", 32'(ssc_if.step_count), 32'(exp_count));
    wait_idle(n);

    // Timeout: no ack.
    ssc_if.stable_sw7 = 1'b0;
    tick();
    ssc_if.stable_sw7 = 1'b1;
    tick();
    hi = 0;
    while (ssc_if.cpu_en && hi < 100) begin
      hi++;
      tick();
    end
    chk("timeout_en_cycles", 32'(hi), 32'(TIMEOUT));
    check_outputs("timeout", 1'b0, 1'b0, exp_count, 1'b1);
    do_step(2, hi);
    exp_count++;
    chk("after_timeout_count", 32'(ssc_if.step_count), 32'(exp_count));
    chk("timeout_err_sticky", 32'(ssc_if.timeout_err), 32'd1);
    wait_idle(n);

    // Ack on the exact timeout cycle wins.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_count = 0;
    do_step(TIMEOUT, hi);
    exp_count++;
    chk("ack_at_timeout_en", 32'(hi), 32'(TIMEOUT));
    check_outputs("ack_at_timeout", 1'b0, 1'b1, exp_count, 1'b0);
    wait_idle(n);
    chk("ack_at_timeout_holdoff", 32'(n), 32'(HOLDOFF));

    // Free-run mode ignores acks and presses.
    ssc_if.run_mode = 1'b1;
    tick();
    chk("run_en", 32'(ssc_if.cpu_en), 32'd1);
    chk("run_busy", 32'(ssc_if.busy), 32'd0);
    en_seen = 0;
    for (int i = 0; i < 10; i++) begin
      ssc_if.cpu_ack    = 1'b1;
      ssc_if.stable_sw7 = i[0];
      tick();
      en_seen += int'(ssc_if.cpu_en);
      ssc_if.cpu_ack = 1'b0;
      tick();
      en_seen += int'(ssc_if.cpu_en);
    end
    ssc_if.stable_sw7 = 1'b0;
    chk("run_en_held", 32'(en_seen), 32'd20);
    chk("run_count", 32'(ssc_if.step_count), 32'(exp_count));
    ssc_if.run_mode = 1'b0;
    tick();
    chk("run_exit_en", 32'(ssc_if.cpu_en), 32'd0);

    // Counter wrap 255 -> 0.
    while (exp_count < 255) begin
      do_step(1, hi);
      exp_count++;
      wait_idle(n);
    end
    chk("count_255", 32'(ssc_if.step_count), 32'd255);
    do_step(1, hi);
    exp_count = 0;
    chk("count_wrap", 32'(ssc_if.step_count), 32'd0);
    wait_idle(n);

    // Asynchronous reset mid-STEP.
    ssc_if.stable_sw7 = 1'b0;
    tick();
    ssc_if.stable_sw7 = 1'b1;
    tick(2);
    chk("pre_reset_en", 32'(ssc_if.cpu_en), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_outputs("async_reset", 1'b0, 1'b0, 0, 1'b0);
    tick();
    reset = 1'b0;
    tick(3);
    chk("post_reset_held_sw", 32'(ssc_if.cpu_en), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
